// File: rtl/mtr_ramp_seq.sv
// Per-wheel duty sequencer: slew-limits signed speed commands once per PWM frame and inserts
// a zero-duty dwell before any direction reversal. Optional deadband kick via MTR_RAMP_KICK_EN.
module mtr_ramp_seq #(
    parameter int unsigned TICK_DIV    = 2048,
    parameter int unsigned STEP        = 16,
    parameter int unsigned DWELL_TICKS = 2,
    parameter int unsigned MIN_DUTY    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_cmd,
    input  logic [11:0] rght_cmd,
    input  logic        cmd_vld,
    input  logic        en,
    input  logic        flt,
    output logic [10:0] lft_spd,
    output logic        lft_rev,
    output logic [10:0] rght_spd,
    output logic        rght_rev,
    output logic        settled,
    output logic        flt_lat
);

    typedef enum logic [1:0] {StRun, StBrake, StDwell} ch_st_e;

`ifdef MTR_RAMP_KICK_EN
    localparam bit KickEn = 1'b1;
`else
    localparam bit KickEn = 1'b0;
`endif

    localparam logic [15:0] TickMax  = 16'(TICK_DIV - 1);
    localparam logic [10:0] StepW    = 11'(STEP);
    localparam logic [3:0]  DwellW   = 4'(DWELL_TICKS);
    localparam logic [10:0] KickDuty = (MIN_DUTY > 2047) ? 11'h7ff : 11'(MIN_DUTY);

    logic [15:0] cnt_q, cnt_d;
    logic        flt_lat_q, flt_lat_d;
    logic        tick;
    ch_st_e      st_q [2];
    ch_st_e      st_d [2];
    logic [10:0] mag_q [2];
    logic [10:0] mag_d [2];
    logic        rev_q [2];
    logic        rev_d [2];
    logic [3:0]  dwl_q [2];
    logic [3:0]  dwl_d [2];
    logic [10:0] tgt_mag_q [2];
    logic [10:0] tgt_mag_d [2];
    logic        tgt_dir_q [2];
    logic        tgt_dir_d [2];

    // One slew step of cur toward tgt, never passing it.
    function automatic logic [10:0] ramp(input logic [10:0] cur, input logic [10:0] tgt);
        logic [10:0] diff;
        logic [10:0] dlt;
        diff = (cur < tgt) ? (tgt - cur) : (cur - tgt);
        dlt  = (diff < StepW) ? diff : StepW;
        if (KickEn && cur == 11'd0 && tgt != 11'd0) begin
            ramp = (tgt < KickDuty) ? tgt : KickDuty;
        end else if (KickEn && tgt < cur && cur <= KickDuty) begin
            ramp = tgt;
        end else if (cur < tgt) begin
            ramp = cur + dlt;
        end else begin
            ramp = cur - dlt;
        end
    endfunction

    assign tick = (cnt_q == TickMax);

    always_comb begin
        logic [11:0] cmd [2];
        logic [11:0] neg;
        logic [10:0] eff;
        logic [10:0] nxt;
        cmd[0]    = lft_cmd;
        cmd[1]    = rght_cmd;
        neg       = '0;
        eff       = '0;
        nxt       = '0;
        cnt_d     = tick ? 16'd0 : cnt_q + 16'd1;
        flt_lat_d = flt_lat_q;
        st_d      = st_q;
        mag_d     = mag_q;
        rev_d     = rev_q;
        dwl_d     = dwl_q;
        tgt_mag_d = tgt_mag_q;
        tgt_dir_d = tgt_dir_q;
        for (int ch = 0; ch < 2; ch++) begin
            eff = en ? tgt_mag_q[ch] : 11'd0;
            if (tick) begin
                case (st_q[ch])
                    StDwell: begin
                        dwl_d[ch] = dwl_q[ch] - 4'd1;
                        if (dwl_q[ch] == 4'd1) begin
                            st_d[ch] = StRun;
                            if (tgt_dir_q[ch] != rev_q[ch]) begin
                                rev_d[ch] = ~rev_q[ch];
                            end
                        end
                    end
                    default: begin
                        // Reversal request: brake to zero first, then dwell.
                        if (tgt_dir_q[ch] != rev_q[ch] && eff != 11'd0) begin
                            nxt       = ramp(mag_q[ch], 11'd0);
                            mag_d[ch] = nxt;
                            if (nxt == 11'd0) begin
                                st_d[ch]  = StDwell;
                                dwl_d[ch] = DwellW;
                            end else begin
                                st_d[ch] = StBrake;
                            end
                        end else begin
                            mag_d[ch] = ramp(mag_q[ch], eff);
                            st_d[ch]  = StRun;
                        end
                    end
                endcase
            end
            if (cmd_vld) begin
                neg           = 12'd0 - cmd[ch];
                tgt_dir_d[ch] = cmd[ch][11];
                if (!cmd[ch][11]) begin
                    tgt_mag_d[ch] = cmd[ch][10:0];
                end else if (cmd[ch] == 12'h800) begin
                    tgt_mag_d[ch] = 11'h7ff;
                end else begin
                    tgt_mag_d[ch] = neg[10:0];
                end
            end
        end
        if (flt_lat_q || flt) begin
            flt_lat_d = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                st_d[ch]      = StRun;
                mag_d[ch]     = '0;
                rev_d[ch]     = 1'b0;
                dwl_d[ch]     = '0;
                tgt_mag_d[ch] = '0;
                tgt_dir_d[ch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            flt_lat_q <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                st_q[ch]      <= StRun;
                mag_q[ch]     <= '0;
                rev_q[ch]     <= 1'b0;
                dwl_q[ch]     <= '0;
                tgt_mag_q[ch] <= '0;
                tgt_dir_q[ch] <= 1'b0;
            end
        end else begin
            cnt_q     <= cnt_d;
            flt_lat_q <= flt_lat_d;
            st_q      <= st_d;
            mag_q     <= mag_d;
            rev_q     <= rev_d;
            dwl_q     <= dwl_d;
            tgt_mag_q <= tgt_mag_d;
            tgt_dir_q <= tgt_dir_d;
        end
    end

    always_comb begin
        logic [10:0] eff;
        eff     = '0;
        settled = ~flt_lat_q;
        for (int ch = 0; ch < 2; ch++) begin
            eff = en ? tgt_mag_q[ch] : 11'd0;
            if (st_q[ch] != StRun || mag_q[ch] != eff || rev_q[ch] != tgt_dir_q[ch]) begin
                settled = 1'b0;
            end
        end
    end

    assign lft_spd  = mag_q[0];
    assign lft_rev  = rev_q[0];
    assign rght_spd = mag_q[1];
    assign rght_rev = rev_q[1];
    assign flt_lat  = flt_lat_q;

endmodule

// File: tb/tb_mtr_ramp_seq.sv
// Randomized bench for mtr_ramp_seq against an arithmetic reference model of the ramp/dwell rules.
module tb_mtr_ramp_seq;

    localparam int TD    = 4;
    localparam int STP   = 16;
    localparam int DWELL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_cmd = '0;
    logic [11:0] rght_cmd = '0;
    logic        cmd_vld = 1'b0;
    logic        en = 1'b1;
    logic        flt = 1'b0;
    logic [10:0] lft_spd, rght_spd;
    logic        lft_rev, rght_rev, settled, flt_lat;

    int n_chk = 0;
    int n_err = 0;

    mtr_ramp_seq #(
        .TICK_DIV   (TD),
        .STEP       (STP),
        .DWELL_TICKS(DWELL),
        .MIN_DUTY   (64)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .lft_cmd (lft_cmd),
        .rght_cmd(rght_cmd),
        .cmd_vld (cmd_vld),
        .en      (en),
        .flt     (flt),
        .lft_spd (lft_spd),
        .lft_rev (lft_rev),
        .rght_spd(rght_spd),
        .rght_rev(rght_rev),
        .settled (settled),
        .flt_lat (flt_lat)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = driving, 1 = braking for reversal, 2 = dwelling at zero.
    int m_cnt, m_flt;
    int m_mag [2];
    int m_rev [2];
    int m_ph [2];
    int m_dwl [2];
    int m_tmag [2];
    int m_tdir [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int approach(input int cur, input int tgt);
        int gap;
        gap = (cur < tgt) ? tgt - cur : cur - tgt;
        if (gap > STP) gap = STP;
        return (cur < tgt) ? cur + gap : cur - gap;
    endfunction

    function automatic int exp_settled();
        if (m_flt != 0) return 0;
        for (int c = 0; c < 2; c++) begin
            if (m_ph[c] != 0 || m_mag[c] != (en ? m_tmag[c] : 0) || m_rev[c] != m_tdir[c]) return 0;
        end
        return 1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_mag[c] = 0; m_rev[c] = 0; m_ph[c] = 0; m_dwl[c] = 0; m_tmag[c] = 0; m_tdir[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit tk;
        int v, eff;
        int cmd [2];
        if (rst) begin
            m_cnt = 0; m_flt = 0;
            model_clear();
            return;
        end
        tk    = (m_cnt == TD - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        if (m_flt != 0 || flt) begin
            m_flt = 1;
            model_clear();
            return;
        end
        if (tk) begin
            for (int c = 0; c < 2; c++) begin
                eff = en ? m_tmag[c] : 0;
                if (m_ph[c] == 2) begin
                    m_dwl[c]--;
                    if (m_dwl[c] == 0) begin
                        if (m_tdir[c] != m_rev[c]) m_rev[c] = 1 - m_rev[c];
                        m_ph[c] = 0;
                    end
                end else if (m_tdir[c] != m_rev[c] && eff > 0) begin
                    m_mag[c] = approach(m_mag[c], 0);
                    m_ph[c]  = (m_mag[c] == 0) ? 2 : 1;
                    m_dwl[c] = DWELL;
                end else begin
                    m_mag[c] = approach(m_mag[c], eff);
                    m_ph[c]  = 0;
                end
            end
        end
        if (cmd_vld) begin
            cmd[0] = int'($signed(lft_cmd));
            cmd[1] = int'($signed(rght_cmd));
            for (int c = 0; c < 2; c++) begin
                v         = (cmd[c] < 0) ? -cmd[c] : cmd[c];
                m_tmag[c] = (v > 2047) ? 2047 : v;
                m_tdir[c] = (cmd[c] < 0) ? 1 : 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("lft_spd", 32'(lft_spd), m_mag[0]);
        chk("lft_rev", 32'(lft_rev), m_rev[0]);
        chk("rght_spd", 32'(rght_spd), m_mag[1]);
        chk("rght_rev", 32'(rght_rev), m_rev[1]);
        chk("settled", 32'(settled), exp_settled());
        chk("flt_lat", 32'(flt_lat), m_flt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input int l, input int r);
        lft_cmd  = 12'(l);
        rght_cmd = 12'(r);
        cmd_vld  = 1'b1;
        cyc();
        cmd_vld  = 1'b0;
    endtask

    initial begin
        int r;
        run(3);
        rst = 1'b0;
        chk("rst_spd", 32'(lft_spd), 0);
        chk("rst_settled", 32'(settled), 1);
        run(2);

        // Ramp up to +100 on the left channel.
        send(100, 0);
        run(40);
        chk("ramp_final", 32'(lft_spd), 100);
        chk("ramp_settled", 32'(settled), 1);

        // Reversal from +48 to -32.
        send(48, 0);
        run(30);
        send(-32, 0);
        run(40);
        chk("rev_dir", 32'(lft_rev), 1);
        chk("rev_spd", 32'(lft_spd), 32);

        // Full-scale negative on the right.
        send(-32, -2048);
        run(600);
        chk("sat_spd", 32'(rght_spd), 2047);
        chk("sat_rev", 32'(rght_rev), 1);

        // Enable drop at +200, then abort a reversal mid-brake.
        send(200, -2048);
        run(120);
        en = 1'b0;
        run(30);
        en = 1'b1;
        run(60);
        send(-200, -2048);
        run(9);
        send(200, -2048);
        run(60);
        chk("abort_dir", 32'(lft_rev), 0);
        chk("abort_spd", 32'(lft_spd), 200);

        // Fault mid-ramp; commands then ignored until reset.
        send(-500, 300);
        run(10);
        flt = 1'b1;
        cyc();
        flt = 1'b0;
        chk("flt_lat", 32'(flt_lat), 1);
        chk("flt_spd", 32'(rght_spd), 0);
        send(100, 100);
        run(20);
        chk("flt_hold", 32'(lft_spd), 0);
        chk("flt_settled", 32'(settled), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("flt_clear", 32'(flt_lat), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) lft_cmd = 12'h800;
            else if (r < 6) lft_cmd = 12'h7ff;
            else lft_cmd = 12'($urandom_range(0, 4095));
            rght_cmd = (r > 95) ? 12'h800 : 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 63) == 0) rght_cmd = '0;
            cmd_vld = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 63) == 0) en = ~en;
            flt = ($urandom_range(0, 999) == 0);
            rst = (m_flt != 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1999) == 0);
            cyc();
        end
        cmd_vld = 1'b0;
        flt     = 1'b0;
        rst     = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
